// File: rtl/swan128k256_word_io.sv
// rtl/swan128k256_word_io.sv - word-serial key/block loader and result unloader for the SWAN128K256 cores
module swan128k256_word_io #(
    parameter int BLOCK_SIZE = 128,
    parameter int KEY_SIZE   = 256,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           in_data,
    input  logic                  in_is_key,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  core_start,
    output logic [KEY_SIZE-1:0]   core_key,
    output logic [BLOCK_SIZE-1:0] core_inp,
    input  logic [BLOCK_SIZE-1:0] core_out,
    input  logic                  core_ready,
    output logic                  key_loaded,
    output logic                  timeout_err
);
    localparam int KW = KEY_SIZE / 32;
    localparam int BW = BLOCK_SIZE / 32;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_BLK, START, WAIT, UNLOAD} state_t;

    state_t                state_q;
    logic [2:0]            count_q;
    logic [1:0]            idx_q;
    logic [TW-1:0]         tmo_q;
    logic [KEY_SIZE-1:0]   key_q;
    logic [BLOCK_SIZE-1:0] blk_q;
    logic [BLOCK_SIZE-1:0] res_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  start_q;
    logic                  key_loaded_q;
    logic                  tmo_err_q;

    logic                  in_fire;
    logic                  out_fire;
    logic [KEY_SIZE-1:0]   key_wr;
    logic [BLOCK_SIZE-1:0] blk_wr;

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    // Word 0 lands in the most significant bits (big-endian stream order).
    always_comb begin
        key_wr = key_q;
        blk_wr = blk_q;
        for (int i = 0; i < KW; i++) begin
            if (count_q == 3'(i)) key_wr[KEY_SIZE-1-32*i -: 32] = in_data;
        end
        for (int i = 0; i < BW; i++) begin
            if (count_q == 3'(i)) blk_wr[BLOCK_SIZE-1-32*i -: 32] = in_data;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < BW; i++) begin
            if (idx_q == 2'(i)) out_data = res_q[BLOCK_SIZE-1-32*i -: 32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            tmo_q        <= '0;
            key_q        <= '0;
            blk_q        <= '0;
            res_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            start_q      <= 1'b0;
            key_loaded_q <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        count_q <= 3'd1;
                        if (in_is_key) begin
                            key_q   <= key_wr;
                            state_q <= LOAD_KEY;
                        end else begin
                            blk_q   <= blk_wr;
                            state_q <= LOAD_BLK;
                        end
                    end
                end
                LOAD_KEY: begin
                    if (in_fire) begin
                        key_q <= key_wr;
                        if (count_q == 3'(KW - 1)) begin
                            count_q      <= '0;
                            key_loaded_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            count_q <= count_q + 3'd1;
                        end
                    end
                end
                LOAD_BLK: begin
                    if (in_fire) begin
                        blk_q <= blk_wr;
                        if (count_q == 3'(BW - 1)) begin
                            count_q    <= '0;
                            in_ready_q <= 1'b0;
                            start_q    <= 1'b1;
                            state_q    <= START;
                        end else begin
                            count_q <= count_q + 3'd1;
                        end
                    end
                end
                START: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A late core_ready still wins over the abort in the same cycle.
                    if (core_ready) begin
                        res_q       <= core_out;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= UNLOAD;
                    end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
                        tmo_err_q  <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        if (idx_q == 2'(BW - 1)) begin
                            idx_q       <= '0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_valid_q && (idx_q == 2'(BW - 1));
    assign core_start  = start_q;
    assign core_key    = key_q;
    assign core_inp    = blk_q;
    assign key_loaded  = key_loaded_q;
    assign timeout_err = tmo_err_q;

endmodule
